// File: rtl/ppu_sched.sv
// ppu_sched: resyncs the PPU raster, selects its mode at frame boundaries and round-robins two byte requesters onto the PPU input.
// Latency: grant/strobe one cycle after arbitration, at most one byte per 3 cycles; requesters wait (req held) until their gnt pulse.
// Build option PPU_SCHED_LFSR_EN replaces requester 1 with an internal 8-bit Galois LFSR byte source.
module ppu_sched #(
    parameter int         LINE            = 799,
    parameter int         SCREEN          = 524,
    parameter int         FRAMES_PER_MODE = 120,
    parameter logic [7:0] MODE_MASK       = 8'h3F,
    parameter int         SYNC_CYCLES     = 2,
    parameter int         ACK_TIMEOUT     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       auto_en,
    input  logic [2:0] host_mode,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       ppu_sync,
    output logic [2:0] ppu_mode,
    output logic [7:0] ppu_data,
    output logic       ppu_stb,
    input  logic       ppu_ack,
    output logic       busy,
    output logic       err
);
    localparam int SXW = (LINE > 0) ? $clog2(LINE + 1) : 1;
    localparam int SYW = (SCREEN > 0) ? $clog2(SCREEN + 1) : 1;
    localparam int SCW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
    localparam int WCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [SXW-1:0] SX_LAST   = SXW'(LINE);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(SCREEN);
    localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_CYCLES - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]     FPM_LAST  = 8'(FRAMES_PER_MODE - 1);

    function automatic logic [2:0] first_mode();
        logic [2:0] m;
        m = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (MODE_MASK[i]) m = 3'(i);
        end
        return m;
    endfunction

    // Scans from the farthest offset down so the nearest enabled mode above cur wins.
    function automatic logic [2:0] next_mode(input logic [2:0] cur);
        logic [2:0] m;
        logic [2:0] cand;
        m = cur;
        for (int i = 7; i >= 1; i--) begin
            cand = cur + 3'(i);
            if (MODE_MASK[cand]) m = cand;
        end
        return m;
    endfunction

    localparam logic [2:0] MODE_FIRST = first_mode();

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_RUN} state_t;
    typedef enum logic [1:0] {XS_ARB, XS_XFER, XS_WAIT} xstate_t;

    state_t         state;
    xstate_t        xs;
    logic [SXW-1:0] sx;
    logic [SYW-1:0] sy;
    logic [7:0]     fcnt;
    logic [SCW-1:0] sync_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           last1;
    logic           req1_eff;
    logic [7:0]     data1_eff;
    logic           pick1;

`ifdef PPU_SCHED_LFSR_EN
    logic [7:0] lfsr;
    logic       unused_req1;
    logic       lfsr_step;

    assign unused_req1 = ^{req1, data1};
    assign req1_eff    = 1'b1;
    assign data1_eff   = lfsr;
    assign lfsr_step   = (state == ST_RUN) && (xs == XS_ARB) && !stop && !start && pick1;

    // Advances on the same edge that registers the current value as the granted byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else if (start && !stop) begin
            lfsr <= 8'hA5;
        end else if (lfsr_step) begin
            lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end
`else
    assign req1_eff  = req1;
    assign data1_eff = data1;
`endif

    assign pick1 = req1_eff && (!req0 || !last1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            xs       <= XS_ARB;
            sx       <= '0;
            sy       <= '0;
            fcnt     <= 8'd0;
            sync_cnt <= '0;
            wait_cnt <= '0;
            last1    <= 1'b1;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            ppu_sync <= 1'b0;
            ppu_mode <= MODE_FIRST;
            ppu_data <= 8'd0;
            ppu_stb  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            ppu_stb <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                xs       <= XS_ARB;
                busy     <= 1'b0;
                ppu_sync <= 1'b0;
            end else if (start) begin
                state    <= ST_SYNC;
                xs       <= XS_ARB;
                busy     <= 1'b1;
                ppu_sync <= 1'b1;
                sync_cnt <= '0;
                sx       <= '0;
                sy       <= '0;
                fcnt     <= 8'd0;
                err      <= 1'b0;
            end else begin
                case (state)
                    ST_SYNC: begin
                        sx   <= '0;
                        sy   <= '0;
                        fcnt <= 8'd0;
                        err  <= 1'b0;
                        xs   <= XS_ARB;
                        if (sync_cnt == SYNC_LAST) begin
                            state    <= ST_RUN;
                            ppu_sync <= 1'b0;
                        end else begin
                            sync_cnt <= sync_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (sx == SX_LAST) begin
                            sx <= '0;
                            sy <= (sy == SY_LAST) ? '0 : sy + 1'b1;
                        end else begin
                            sx <= sx + 1'b1;
                        end
                        // Mode only moves on the last pixel of a frame.
                        if (sx == SX_LAST && sy == SY_LAST) begin
                            if (auto_en) begin
                                if (fcnt == FPM_LAST) begin
                                    fcnt     <= 8'd0;
                                    ppu_mode <= next_mode(ppu_mode);
                                end else begin
                                    fcnt <= fcnt + 8'd1;
                                end
                            end else begin
                                ppu_mode <= host_mode;
                                fcnt     <= 8'd0;
                            end
                        end
                        case (xs)
                            XS_ARB: begin
                                if (req0 || req1_eff) begin
                                    xs      <= XS_XFER;
                                    ppu_stb <= 1'b1;
                                    last1   <= pick1;
                                    if (pick1) begin
                                        ppu_data <= data1_eff;
                                        gnt1     <= 1'b1;
                                    end else begin
                                        ppu_data <= data0;
                                        gnt0     <= 1'b1;
                                    end
                                end
                            end
                            XS_XFER: begin
                                xs       <= XS_WAIT;
                                wait_cnt <= '0;
                            end
                            XS_WAIT: begin
                                if (ppu_ack) begin
                                    xs <= XS_ARB;
                                end else if (wait_cnt == WAIT_LAST) begin
                                    err <= 1'b1;
                                    xs  <= XS_ARB;
                                end else begin
                                    wait_cnt <= wait_cnt + 1'b1;
                                end
                            end
                            default: xs <= XS_ARB;
                        endcase
                    end
                    default: begin
                        xs <= XS_ARB;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ppu_sched.sv
// Randomized bench for ppu_sched against a transaction/frame-level reference model; small raster so mode changes are reachable.
module tb_ppu_sched;
    localparam int         LINE        = 9;
    localparam int         SCREEN      = 4;
    localparam int         FPM         = 2;
    localparam logic [7:0] MASK        = 8'h85;
    localparam int         SYNC_CYCLES = 2;
    localparam int         ACK_TIMEOUT = 4;
    localparam int         FRAME       = (LINE + 1) * (SCREEN + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, auto_en = 1'b0;
    logic [2:0] host_mode = 3'd0;
    logic       req0 = 1'b0, req1 = 1'b0, ppu_ack = 1'b0;
    logic [7:0] data0 = 8'd0, data1 = 8'd0;
    logic       gnt0, gnt1, ppu_sync, ppu_stb, busy, err;
    logic [2:0] ppu_mode;
    logic [7:0] ppu_data;

    ppu_sched #(
        .LINE(LINE), .SCREEN(SCREEN), .FRAMES_PER_MODE(FPM), .MODE_MASK(MASK),
        .SYNC_CYCLES(SYNC_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .auto_en(auto_en), .host_mode(host_mode),
        .req0(req0), .data0(data0), .gnt0(gnt0), .req1(req1), .data1(data1), .gnt1(gnt1),
        .ppu_sync(ppu_sync), .ppu_mode(ppu_mode), .ppu_data(ppu_data), .ppu_stb(ppu_stb),
        .ppu_ack(ppu_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
    endtask

    // Stimulus knobs
    bit         k_start = 0, k_stop = 0, k_stop_xfer = 0;
    bit         k_en0 = 0, k_en1 = 0, k_hold = 0, k_auto = 1;
    logic [2:0] k_host = 3'd0;
    logic [7:0] k_d0 = 8'd0, k_d1 = 8'd0;
    int         k_ack = 0;

    // Reference model: FSM phase, frame/mode bookkeeping, transfer timeline
    int         m_state = 0;
    int         m_sync_left = 0;
    int         m_rc = 0;
    int         m_frames = 0;
    logic [2:0] m_mode;
    logic       m_err = 1'b0;
    bit         m_xbusy = 0;
    int         m_stb_at = 0;
    bit         m_last1 = 1;
    logic [7:0] m_lfsr = 8'hA5;
    bit         e_stb = 0, e_g0 = 0, e_g1 = 0;
    logic [7:0] e_data = 8'd0;

    bit         seen_g0 = 0, seen_g1 = 0;
    int         last_stb = -10;
    int         stb_cyc_q[$];
    logic [7:0] stb_dat_q[$];

    function automatic logic [2:0] lowest_mode();
        for (int i = 0; i < 8; i++) if (MASK[i]) return 3'(i);
        return 3'd0;
    endfunction

    function automatic logic [2:0] following_mode(input logic [2:0] cur);
        int m;
        for (int k = 1; k <= 8; k++) begin
            m = (int'(cur) + k) % 8;
            if (MASK[m]) return 3'(m);
        end
        return cur;
    endfunction

`ifdef PPU_SCHED_LFSR_EN
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] n;
        n = v >> 1;
        if (v[0]) begin
            n[7] = ~n[7]; n[5] = ~n[5]; n[4] = ~n[4]; n[3] = ~n[3];
        end
        return n;
    endfunction
`endif

    task automatic next_req(input bit en, input bit granted, input logic [7:0] hold_d,
                            inout logic r, inout logic [7:0] d);
        if (!en) r = 1'b0;
        else if (k_hold) begin r = 1'b1; d = hold_d; end
        else if (granted) r = 1'b0;
        else if (!r && $urandom_range(0, 2) == 0) begin r = 1'b1; d = 8'($urandom); end
    endtask

    task automatic drive();
        start   = k_start;
        k_start = 0;
        stop    = k_stop || (k_stop_xfer && e_stb);
        if (stop) begin k_stop = 0; k_stop_xfer = 0; end
        auto_en   = k_auto;
        host_mode = k_host;
        next_req(k_en0, seen_g0, k_d0, req0, data0);
        next_req(k_en1, seen_g1, k_d1, req1, data1);
        case (k_ack)
            0:       ppu_ack = ($urandom_range(0, 3) == 0);
            1:       ppu_ack = (cyc == last_stb + 1);
            default: ppu_ack = 1'b0;
        endcase
    endtask

    task automatic check_cycle();
        check("busy", busy, m_state != 0);
        check("sync", ppu_sync, m_state == 1);
        check("mode", ppu_mode, m_mode);
        check("err", err, m_err);
        check("stb", ppu_stb, e_stb);
        check("gnt0", gnt0, e_g0);
        check("gnt1", gnt1, e_g1);
        if (e_stb) check("data", ppu_data, e_data);
        seen_g0 = gnt0;
        seen_g1 = gnt1;
        if (ppu_stb) begin
            last_stb = cyc;
            stb_cyc_q.push_back(cyc);
            stb_dat_q.push_back(ppu_data);
        end
    endtask

    task automatic model_update();
        logic       r1;
        logic [7:0] d1;
        bit         w1;
`ifdef PPU_SCHED_LFSR_EN
        r1 = 1'b1; d1 = m_lfsr;
`else
        r1 = req1; d1 = data1;
`endif
        e_stb = 0; e_g0 = 0; e_g1 = 0;
        if (stop) begin
            m_state = 0; m_xbusy = 0;
        end else if (start) begin
            m_state = 1; m_sync_left = SYNC_CYCLES; m_err = 1'b0;
            m_xbusy = 0; m_frames = 0; m_lfsr = 8'hA5;
        end else if (m_state == 1) begin
            m_sync_left--;
            if (m_sync_left == 0) begin m_state = 2; m_rc = 0; end
        end else if (m_state == 2) begin
            if (!m_xbusy) begin
                if (req0 || r1) begin
                    w1 = r1 && (!req0 || !m_last1);
                    e_stb = 1; e_g0 = !w1; e_g1 = w1;
                    e_data = w1 ? d1 : data0;
                    m_last1 = w1; m_xbusy = 1; m_stb_at = cyc + 1;
`ifdef PPU_SCHED_LFSR_EN
                    if (w1) m_lfsr = lfsr_next(m_lfsr);
`endif
                end
            end else if (cyc > m_stb_at) begin
                if (ppu_ack) m_xbusy = 0;
                else if (cyc == m_stb_at + ACK_TIMEOUT) begin m_xbusy = 0; m_err = 1'b1; end
            end
            if (m_rc % FRAME == FRAME - 1) begin
                if (auto_en) begin
                    m_frames++;
                    if (m_frames == FPM) begin m_frames = 0; m_mode = following_mode(m_mode); end
                end else begin
                    m_mode = host_mode; m_frames = 0;
                end
            end
            m_rc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        check_cycle();
        model_update();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int         sync_n;
        int         stop_cyc;
        logic [7:0] exp_d;
        m_mode = lowest_mode();

        // Reset held, then idle with no stimulus
        run(3);
        rst = 1'b1;
        run(20);

        // Start: sync pulse width, then strict alternation with prompt acks
        k_en0 = 1; k_en1 = 1; k_hold = 1; k_d0 = 8'h11; k_d1 = 8'h22; k_ack = 1;
        stb_cyc_q.delete(); stb_dat_q.delete();
        k_start = 1;
        sync_n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            sync_n += int'(ppu_sync);
        end
        check("sync_len", sync_n, SYNC_CYCLES);
        run(14);
        check("alt_count", stb_dat_q.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < stb_dat_q.size(); i++) begin
            exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
            check("alt_data", stb_dat_q[i], exp_d);
            if (i > 0) check("alt_gap", stb_cyc_q[i] - stb_cyc_q[i-1], 3);
        end

        // Random traffic and acks across several auto mode periods
        k_hold = 0; k_ack = 0; k_auto = 1;
        run(650);

        // Host-selected modes, then back to auto
        k_auto = 0; k_host = 3'd5;
        run(120);
        k_host = 3'd3;
        run(60);
        k_auto = 1;
        run(130);

        // Ack never arrives: timeout spacing and sticky err, cleared by start
        k_en1 = 0; k_en0 = 1; k_hold = 1; k_d0 = 8'h5A; k_ack = 2;
        k_start = 1;
        step();
        stb_cyc_q.delete(); stb_dat_q.delete();
        run(30);
        check("to_err", err, 1'b1);
        check("to_count", stb_cyc_q.size() >= 3, 1'b1);
        for (int i = 1; i < 3 && i < stb_cyc_q.size(); i++)
            check("to_gap", stb_cyc_q[i] - stb_cyc_q[i-1], ACK_TIMEOUT + 2);
        k_start = 1;
        step();
        step();
        check("err_clr", err, 1'b0);

        // Stop in the transfer cycle
        k_ack = 1; k_stop_xfer = 1;
        run(12);
        stop_cyc = last_stb;
        stb_cyc_q.delete();
        run(10);
        check("stop_busy", busy, 1'b0);
        check("stop_no_stb", stb_cyc_q.size(), 0);
        check("stop_seen", stop_cyc > 0, 1'b1);

`ifdef PPU_SCHED_LFSR_EN
        // LFSR source alone: seed then its successor
        k_en0 = 0; k_ack = 1;
        k_start = 1;
        step();
        stb_dat_q.delete();
        run(12);
        check("lfsr_count", stb_dat_q.size() >= 2, 1'b1);
        if (stb_dat_q.size() >= 2) begin
            check("lfsr_first", stb_dat_q[0], 8'hA5);
            check("lfsr_second", stb_dat_q[1], 8'hEA);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
